fetch_buffer: RTL and testbench
===============================

# fetch_buffer

Two-wide instruction queue between the fetch stage and decode. Captures up to two fetched instruction packets per cycle from fetch: address, instruction word, and BTB prediction. Holds them in a circular buffer and presents up to two oldest packets per cycle to decode. Decouples fetch from decode back-pressure and drops all in-flight packets on a pipeline flush (branch mispredict or exception redirect).

## Interface
Parameters:
- ADDR_WIDTH, 32, instruction address width
- DATA_WIDTH, 32, instruction word width
- DEPTH, 8, entries; power of two, ≥ 4

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- flush  input  1  synchronous discard of all entries
- in_valid  input  2  per-slot enqueue valid from fetch; bit 0 = slot 0 (older)
- in_addr_0 / in_addr_1  input  ADDR_WIDTH  slot PCs
- in_instr_0 / in_instr_1  input  DATA_WIDTH  slot instruction words
- in_pred_taken_0 / in_pred_taken_1  input  1  BTB taken prediction per slot
- in_pred_target_0 / in_pred_target_1  input  ADDR_WIDTH  BTB predicted target per slot
- in_ready  output  1  buffer can accept two packets this cycle
- out_valid  output  2  bit 0: head valid; bit 1: head+1 valid
- out_addr_0 / out_addr_1, out_instr_0 / out_instr_1, out_pred_taken_0 / out_pred_taken_1, out_pred_target_0 / out_pred_target_1  output  as inputs  head and head+1 packet fields
- out_accept  input  2  decode consumes slot 0 / slot 1 this cycle
- occupancy  output  $clog2(DEPTH)+1  current entry count

## Operation
- Storage: DEPTH entries of {addr, instr, pred_taken, pred_target}.
- Pointers and count:
  - head and tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is a separate register.
- in_ready = (DEPTH − count) ≥ 2, computed from the registered count only. Same-cycle dequeues do not raise in_ready.
- Enqueue (only when in_ready = 1 and flush = 0):
  - Valid slots are written in order, slot 0 then slot 1, compacted at tail.
  - in_valid = 01 or 10 writes one entry at tail.
  - in_valid = 11 writes tail and tail+1.
  - tail advances by the number of valid slots.
  - When in_ready = 0, inputs are ignored. Fetch holds its packets.
- Output:
  - out_valid[0] = count ≥ 1; out_valid[1] = count ≥ 2.
  - out_* _0 reads entry[head] combinationally; out_* _1 reads entry[head+1 mod DEPTH].
  - Data fields are don't-care when the corresponding valid bit is 0.
- Dequeue:
  - deq = 0 unless out_accept[0] & out_valid[0].
  - If deq is already 1, it becomes 2 when out_accept[1] & out_valid[1] are also set.
  - out_accept = 10 dequeues nothing (in-order consumption only).
  - Accepts on invalid slots are ignored.
  - head advances by deq.
- Count update: count_next = count + enq − deq. Simultaneous enqueue and dequeue are allowed in every state.
- Flush has highest priority: head, tail, and count go to 0, and same-cycle enqueue and dequeue are discarded.
- No other state machine. Buffer states are empty (count = 0), partial, almost-full (count ≥ DEPTH−1), and full (count = DEPTH).

## Timing
- Reset (rst = 0, asynchronous): head = tail = count = 0. Resulting outputs:
  - in_ready = 1
  - out_valid = 00
  - occupancy = 0
  - Entry contents are not reset.
- Enqueue at edge N is visible at out_* at N+1; minimum fall-through latency is 1 cycle, with no bypass.
- Dequeue at edge N removes entries; out_* shows the next entries after N.
- Flush asserted at edge N: out_valid = 00 after N. An enqueue presented at N+1 appears at N+2.
- in_ready deasserts when count ≥ DEPTH−1, so one free slot may remain unused; this is intended.
- Wrap-around: a write at tail = DEPTH−1 with in_valid = 11 places slot 1 at entry 0.
- rst deasserted mid-stream: the queue is empty on the first active edge; no stale packets are output.

## Test plan
- Reset then idle:
  - Stimulus: rst low for 2 cycles, then high, with no traffic.
  - Required: in_ready = 1, out_valid = 00, occupancy = 0.
- Dual enqueue and passthrough:
  - Stimulus: in_valid = 11, addr 0x100/0x104, instr 0x00000013/0x00100093; out_accept = 11 next cycle.
  - Required: the next cycle shows out_valid = 11 with those fields; the cycle after shows occupancy = 0.
- Fill to back-pressure:
  - Stimulus: DEPTH = 8, enqueue 11 for 4 cycles, out_accept = 00.
  - Required: occupancy = 8 and in_ready = 0. A 5th-cycle in_valid = 11 with addr 0x200 is not stored. Draining 2 restores in_ready = 1.
- Wrap and compaction:
  - Stimulus: pre-fill 7, drain 7, then enqueue in_valid = 10 with addr 0x300, then 11 with addr 0x304/0x308.
  - Required: output order is 0x300, 0x304, 0x308; head wraps correctly.
- Partial accept and simultaneous enq/deq:
  - Stimulus: occupancy 3, out_accept = 01 with in_valid = 11 in the same cycle.
  - Required: occupancy = 4 and FIFO order is preserved. out_accept = 10 dequeues nothing.
- Flush priority:
  - Stimulus: occupancy 5, assert flush together with in_valid = 11 and out_accept = 11.
  - Required: next cycle occupancy = 0, out_valid = 00, and the flushed-cycle inputs are absent.

Source files
------------

// File: rtl/fetch_buffer.sv
// fetch_buffer: two-wide circular instruction queue between fetch and decode.
// Accepts up to two packets per cycle, presents the two oldest to decode,
// and discards everything on flush.
module fetch_buffer #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [1:0]                   in_valid,
  input  logic [ADDR_WIDTH-1:0]        in_addr_0,
  input  logic [ADDR_WIDTH-1:0]        in_addr_1,
  input  logic [DATA_WIDTH-1:0]        in_instr_0,
  input  logic [DATA_WIDTH-1:0]        in_instr_1,
  input  logic                         in_pred_taken_0,
  input  logic                         in_pred_taken_1,
  input  logic [ADDR_WIDTH-1:0]        in_pred_target_0,
  input  logic [ADDR_WIDTH-1:0]        in_pred_target_1,
  output logic                         in_ready,
  output logic [1:0]                   out_valid,
  output logic [ADDR_WIDTH-1:0]        out_addr_0,
  output logic [ADDR_WIDTH-1:0]        out_addr_1,
  output logic [DATA_WIDTH-1:0]        out_instr_0,
  output logic [DATA_WIDTH-1:0]        out_instr_1,
  output logic                         out_pred_taken_0,
  output logic                         out_pred_taken_1,
  output logic [ADDR_WIDTH-1:0]        out_pred_target_0,
  output logic [ADDR_WIDTH-1:0]        out_pred_target_1,
  input  logic [1:0]                   out_accept,
  output logic [$clog2(DEPTH):0]       occupancy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = 2 * ADDR_WIDTH + DATA_WIDTH + 1;

  // Entry layout: {addr, instr, pred_taken, pred_target}
  logic [EW-1:0]  r_mem [DEPTH];
  logic [PW-1:0]  r_head;
  logic [PW-1:0]  r_tail;
  logic [CW-1:0]  r_count;

  logic           w_enq;
  logic [1:0]     w_enq_num;
  logic [1:0]     w_deq_num;
  logic           w_wr0_en;
  logic           w_wr1_en;
  logic [PW-1:0]  w_tail_p1;
  logic [PW-1:0]  w_head_p1;
  logic [EW-1:0]  w_slot0;
  logic [EW-1:0]  w_slot1;
  logic [EW-1:0]  w_wr0_data;
  logic [EW-1:0]  w_rd0;
  logic [EW-1:0]  w_rd1;

  assign w_slot0   = {in_addr_0, in_instr_0, in_pred_taken_0, in_pred_target_0};
  assign w_slot1   = {in_addr_1, in_instr_1, in_pred_taken_1, in_pred_target_1};
  assign w_tail_p1 = r_tail + PW'(1);
  assign w_head_p1 = r_head + PW'(1);

  // Ready, enqueue/dequeue amounts and write-port steering (compaction at tail)
  always_comb begin
    in_ready   = (CW'(DEPTH) - r_count) >= CW'(2);
    w_enq      = in_ready & ~flush;
    w_enq_num  = '0;
    if (w_enq) begin
      w_enq_num = {1'b0, in_valid[0]} + {1'b0, in_valid[1]};
    end
    w_deq_num  = '0;
    if (out_accept[0] && out_valid[0]) begin
      w_deq_num = 2'd1;
      if (out_accept[1] && out_valid[1]) begin
        w_deq_num = 2'd2;
      end
    end
    w_wr0_en   = w_enq & (|in_valid);
    w_wr1_en   = w_enq & (&in_valid);
    w_wr0_data = in_valid[0] ? w_slot0 : w_slot1;
  end

  // Entry storage; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (w_wr0_en) begin
      r_mem[r_tail] <= w_wr0_data;
    end
    if (w_wr1_en) begin
      r_mem[w_tail_p1] <= w_slot1;
    end
  end

  // Pointer and count update; flush overrides any same-cycle enqueue/dequeue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_deq_num);
      r_tail  <= r_tail + PW'(w_enq_num);
      r_count <= r_count + CW'(w_enq_num) - CW'(w_deq_num);
    end
  end

  // Output view of head and head+1
  always_comb begin
    w_rd0             = r_mem[r_head];
    w_rd1             = r_mem[w_head_p1];
    out_valid         = {r_count >= CW'(2), r_count >= CW'(1)};
    occupancy         = r_count;
    {out_addr_0, out_instr_0, out_pred_taken_0, out_pred_target_0} = w_rd0;
    {out_addr_1, out_instr_1, out_pred_taken_1, out_pred_target_1} = w_rd1;
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed literal checks.
module tb_fetch_buffer;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned DEPTH = 8;

  logic          clk;
  logic          rst;
  logic          flush;
  logic [1:0]    in_valid;
  logic [AW-1:0] in_addr_0, in_addr_1;
  logic [DW-1:0] in_instr_0, in_instr_1;
  logic          in_pred_taken_0, in_pred_taken_1;
  logic [AW-1:0] in_pred_target_0, in_pred_target_1;
  logic          in_ready;
  logic [1:0]    out_valid;
  logic [AW-1:0] out_addr_0, out_addr_1;
  logic [DW-1:0] out_instr_0, out_instr_1;
  logic          out_pred_taken_0, out_pred_taken_1;
  logic [AW-1:0] out_pred_target_0, out_pred_target_1;
  logic [1:0]    out_accept;
  logic [3:0]    occupancy;

  int total = 0;
  int bad = 0;

  fetch_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .in_addr_0(in_addr_0), .in_addr_1(in_addr_1),
    .in_instr_0(in_instr_0), .in_instr_1(in_instr_1),
    .in_pred_taken_0(in_pred_taken_0), .in_pred_taken_1(in_pred_taken_1),
    .in_pred_target_0(in_pred_target_0), .in_pred_target_1(in_pred_target_1),
    .in_ready(in_ready), .out_valid(out_valid),
    .out_addr_0(out_addr_0), .out_addr_1(out_addr_1),
    .out_instr_0(out_instr_0), .out_instr_1(out_instr_1),
    .out_pred_taken_0(out_pred_taken_0), .out_pred_taken_1(out_pred_taken_1),
    .out_pred_target_0(out_pred_target_0), .out_pred_target_1(out_pred_target_1),
    .out_accept(out_accept), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] instr;
    logic          taken;
    logic [AW-1:0] target;
  } pkt_t;

  pkt_t mq[$];

  function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endfunction

  // Reference model: a plain FIFO of packets, updated at each clock edge
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
    end else if (flush) begin
      mq.delete();
    end else begin
      int d;
      bit rdy;
      pkt_t p;
      d = 0;
      rdy = (DEPTH - mq.size()) >= 2;
      if (out_accept[0] && mq.size() >= 1) d = 1;
      if (d == 1 && out_accept[1] && mq.size() >= 2) d = 2;
      for (int i = 0; i < d; i++) void'(mq.pop_front());
      if (rdy) begin
        if (in_valid[0]) begin
          p.addr = in_addr_0; p.instr = in_instr_0;
          p.taken = in_pred_taken_0; p.target = in_pred_target_0;
          mq.push_back(p);
        end
        if (in_valid[1]) begin
          p.addr = in_addr_1; p.instr = in_instr_1;
          p.taken = in_pred_taken_1; p.target = in_pred_target_1;
          mq.push_back(p);
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (rst) begin
      check("m_occ", 64'(occupancy), 64'(mq.size()));
      check("m_ready", 64'(in_ready), 64'((DEPTH - mq.size()) >= 2));
      check("m_valid", 64'(out_valid), 64'({mq.size() >= 2, mq.size() >= 1}));
      if (mq.size() >= 1) begin
        check("m_addr0", 64'(out_addr_0), 64'(mq[0].addr));
        check("m_instr0", 64'(out_instr_0), 64'(mq[0].instr));
        check("m_taken0", 64'(out_pred_taken_0), 64'(mq[0].taken));
        check("m_tgt0", 64'(out_pred_target_0), 64'(mq[0].target));
      end
      if (mq.size() >= 2) begin
        check("m_addr1", 64'(out_addr_1), 64'(mq[1].addr));
        check("m_instr1", 64'(out_instr_1), 64'(mq[1].instr));
        check("m_taken1", 64'(out_pred_taken_1), 64'(mq[1].taken));
        check("m_tgt1", 64'(out_pred_target_1), 64'(mq[1].target));
      end
    end
  end

  // Apply one cycle of stimulus (called at a falling edge), return at next falling edge
  task automatic drive(input logic [1:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] i0, input logic [DW-1:0] i1,
                       input logic [1:0] acc, input logic fl);
    in_valid = v;
    in_addr_0 = a0; in_addr_1 = a1;
    in_instr_0 = i0; in_instr_1 = i1;
    in_pred_taken_0 = a0[3]; in_pred_taken_1 = a1[3];
    in_pred_target_0 = a0 + 32'h80; in_pred_target_1 = a1 + 32'h80;
    out_accept = acc;
    flush = fl;
    @(negedge clk);
    in_valid = 2'b00; out_accept = 2'b00; flush = 1'b0;
  endtask

  task automatic enq(input logic [1:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    drive(v, a0, a1, a0 ^ 32'h5a5a0000, a1 ^ 32'h5a5a0000, 2'b00, 1'b0);
  endtask

  task automatic acc(input logic [1:0] a);
    drive(2'b00, '0, '0, '0, '0, a, 1'b0);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = '0; out_accept = '0;
    in_addr_0 = '0; in_addr_1 = '0; in_instr_0 = '0; in_instr_1 = '0;
    in_pred_taken_0 = 1'b0; in_pred_taken_1 = 1'b0;
    in_pred_target_0 = '0; in_pred_target_1 = '0;

    // Reset then idle
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_occ", 64'(occupancy), 64'd0);
    rst = 1'b1;
    acc(2'b00);
    check("idle_occ", 64'(occupancy), 64'd0);

    // Dual enqueue and passthrough
    drive(2'b11, 32'h100, 32'h104, 32'h00000013, 32'h00100093, 2'b00, 1'b0);
    check("dual_valid", 64'(out_valid), 64'd3);
    check("dual_addr0", 64'(out_addr_0), 64'h100);
    check("dual_addr1", 64'(out_addr_1), 64'h104);
    check("dual_instr0", 64'(out_instr_0), 64'h00000013);
    check("dual_instr1", 64'(out_instr_1), 64'h00100093);
    check("dual_tgt0", 64'(out_pred_target_0), 64'h180);
    acc(2'b11);
    check("pass_occ", 64'(occupancy), 64'd0);
    check("pass_valid", 64'(out_valid), 64'd0);

    // Fill to back-pressure
    for (int k = 0; k < 4; k++) enq(2'b11, 32'h10 + 32'(k * 8), 32'h14 + 32'(k * 8));
    check("full_occ", 64'(occupancy), 64'd8);
    check("full_ready", 64'(in_ready), 64'd0);
    enq(2'b11, 32'h200, 32'h204);
    check("full_drop_occ", 64'(occupancy), 64'd8);
    check("full_head", 64'(out_addr_0), 64'h10);
    acc(2'b11);
    check("drain_ready", 64'(in_ready), 64'd1);
    check("drain_occ", 64'(occupancy), 64'd6);
    check("drain_head", 64'(out_addr_0), 64'h18);
    repeat (3) acc(2'b11);
    check("drained_occ", 64'(occupancy), 64'd0);

    // Wrap and compaction: leave head/tail at 7
    for (int k = 0; k < 3; k++) enq(2'b11, 32'h20 + 32'(k * 8), 32'h24 + 32'(k * 8));
    enq(2'b01, 32'h38, 32'h0);
    check("pre7_occ", 64'(occupancy), 64'd7);
    check("pre7_ready", 64'(in_ready), 64'd0);
    repeat (3) acc(2'b11);
    acc(2'b01);
    check("wrap_empty", 64'(occupancy), 64'd0);
    enq(2'b10, 32'hdead, 32'h300);
    check("cmp_occ", 64'(occupancy), 64'd1);
    check("cmp_addr0", 64'(out_addr_0), 64'h300);
    enq(2'b11, 32'h304, 32'h308);
    check("wrap_occ", 64'(occupancy), 64'd3);
    check("wrap_addr1", 64'(out_addr_1), 64'h304);
    acc(2'b01);
    check("wrap_h0", 64'(out_addr_0), 64'h304);
    check("wrap_h1", 64'(out_addr_1), 64'h308);
    acc(2'b11);
    check("wrap_done", 64'(occupancy), 64'd0);

    // Partial accept with simultaneous enqueue
    enq(2'b11, 32'h400, 32'h404);
    enq(2'b01, 32'h408, 32'h0);
    check("part_occ3", 64'(occupancy), 64'd3);
    drive(2'b11, 32'h40c, 32'h410, 32'h1, 32'h2, 2'b01, 1'b0);
    check("part_occ4", 64'(occupancy), 64'd4);
    check("part_h0", 64'(out_addr_0), 64'h404);
    check("part_h1", 64'(out_addr_1), 64'h408);
    acc(2'b10);
    check("acc10_occ", 64'(occupancy), 64'd4);
    check("acc10_h0", 64'(out_addr_0), 64'h404);
    acc(2'b11);
    check("part_h0b", 64'(out_addr_0), 64'h40c);
    check("part_instr1", 64'(out_instr_1), 64'h2);
    acc(2'b11);

    // Flush priority, then enqueue right after
    enq(2'b11, 32'h500, 32'h504);
    enq(2'b11, 32'h508, 32'h50c);
    enq(2'b01, 32'h510, 32'h0);
    check("fl_pre", 64'(occupancy), 64'd5);
    drive(2'b11, 32'h600, 32'h604, 32'h0, 32'h0, 2'b11, 1'b1);
    check("fl_occ", 64'(occupancy), 64'd0);
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_ready", 64'(in_ready), 64'd1);
    enq(2'b11, 32'h700, 32'h704);
    check("postfl_addr0", 64'(out_addr_0), 64'h700);
    check("postfl_occ", 64'(occupancy), 64'd2);

    // Asynchronous reset mid-stream
    #2 rst = 1'b0;
    #1;
    check("arst_occ", 64'(occupancy), 64'd0);
    check("arst_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    acc(2'b11);
    check("arst_after", 64'(out_valid), 64'd0);
    enq(2'b01, 32'h800, 32'h0);
    check("arst_new", 64'(out_addr_0), 64'h800);
    acc(2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
